// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Resolves beq/bne branches at the ID/EX boundary and drives the PC-select
// interface. The operands of a branch in ID are compared, the decision is
// registered, and one cycle later a single-cycle redirect pulse is produced
// together with the branch target and a flush of the two wrong-path
// instructions. While the redirect pulse is showing, the branch in ID is on
// the wrong path and is ignored.
//
// Optional feature (compile-time macro): BRANCH_STATS_EN
//   When defined, adds 32-bit wrapping counters of evaluated and taken
//   branches. When undefined, those ports and their logic are absent.
//
// Ports
//   clk_i          in   1   clock, rising edge
//   rst_i          in   1   asynchronous active-high reset
//   stall_i        in   1   load-use stall; ID contents not valid this cycle
//   branch_i       in   1   instruction in ID is a conditional branch
//   bne_i          in   1   1 = bne (taken if unequal), 0 = beq (taken if equal)
//   rs_data_i      in   DW  first operand (forwarded)
//   rt_data_i      in   DW  second operand (forwarded)
//   pc_plus4_i     in   AW  PC+4 of the instruction in ID
//   imm_i          in   AW  sign-extended offset in words
//   branchTaken_o  out  1   PC mux select: 1 = take addrTaken_o
//   addrTaken_o    out  AW  branch target (holds the last taken target)
//   flush_o        out  1   squash IF/ID and ID/EX
//   brCount_o      out  32  branches evaluated   (BRANCH_STATS_EN only)
//   takenCount_o   out  32  branches taken       (BRANCH_STATS_EN only)
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          stall_i,
    input  logic          branch_i,
    input  logic          bne_i,
    input  logic [DW-1:0] rs_data_i,
    input  logic [DW-1:0] rt_data_i,
    input  logic [AW-1:0] pc_plus4_i,
    input  logic [AW-1:0] imm_i,
    output logic          branchTaken_o,
    output logic [AW-1:0] addrTaken_o,
    output logic          flush_o
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]   brCount_o,
    output logic [31:0]   takenCount_o
`endif
);

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;

    logic          evaluate;
    logic          cond;
    logic          take;
    logic [AW-1:0] target;

    // A branch is only looked at when no redirect is in flight (otherwise it
    // is a wrong-path instruction) and ID holds valid, non-stalled contents.
    assign evaluate = (state_q == IDLE) && branch_i && !stall_i;
    assign cond     = bne_i ? (rs_data_i != rt_data_i) : (rs_data_i == rt_data_i);
    assign take     = evaluate && cond;

    // Word offset scaled to bytes; the add is AW bits wide so carry-out is
    // dropped and the target wraps around the address space.
    assign target   = pc_plus4_i + (imm_i << 2);

    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = REDIRECT;
                    addr_d  = target;
                end
            end
            REDIRECT: begin
                // Always exactly one cycle; branch_i and stall_i are ignored.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others, matching real hardware.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // The redirect pulse is exactly the REDIRECT state, so it is one cycle
    // wide by construction and drops as soon as reset asserts.
    assign branchTaken_o = (state_q == REDIRECT);
    assign flush_o       = (state_q == REDIRECT);
    assign addrTaken_o   = addr_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] br_count_q, br_count_d;
    logic [31:0] taken_count_q, taken_count_d;

    // Natural 32-bit wrap from 0xFFFFFFFF to 0.
    assign br_count_d    = evaluate ? br_count_q + 32'd1 : br_count_q;
    assign taken_count_d = take     ? taken_count_q + 32'd1 : taken_count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            br_count_q    <= '0;
            taken_count_q <= '0;
        end else begin
            br_count_q    <= br_count_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign brCount_o    = br_count_q;
    assign takenCount_o = taken_count_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Directed stimulus for branch_resolve_unit. A behavioural model tracks what
// the PC-select outputs must be from the branch rules (compare operands,
// target = pc+4 + 4*offset, one redirect per taken branch, wrong-path
// branches ignored while a redirect is showing). A compare process checks
// the DUT against the model on every falling edge; hand-computed literal
// expectations pin the model at key points. Build with +define+BRANCH_STATS_EN
// to include the statistics counters.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        branch_i;
    logic        bne_i;
    logic [31:0] rs_data_i;
    logic [31:0] rt_data_i;
    logic [31:0] pc_plus4_i;
    logic [31:0] imm_i;
    logic        branchTaken_o;
    logic [31:0] addrTaken_o;
    logic        flush_o;
`ifdef BRANCH_STATS_EN
    logic [31:0] brCount_o;
    logic [31:0] takenCount_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    branch_resolve_unit #(.AW(32), .DW(32)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .branch_i      (branch_i),
        .bne_i         (bne_i),
        .rs_data_i     (rs_data_i),
        .rt_data_i     (rt_data_i),
        .pc_plus4_i    (pc_plus4_i),
        .imm_i         (imm_i),
        .branchTaken_o (branchTaken_o),
        .addrTaken_o   (addrTaken_o),
        .flush_o       (flush_o)
`ifdef BRANCH_STATS_EN
        ,
        .brCount_o     (brCount_o),
        .takenCount_o  (takenCount_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    // m_pulse is the redirect the PC mux should currently see. While it is
    // showing, the branch sitting in ID is a wrong-path instruction.
    logic        m_pulse = 1'b0;
    logic [31:0] m_addr  = 32'h0;
    int unsigned m_evals = 0;
    int unsigned m_taken = 0;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_pulse = 1'b0;
            m_addr  = 32'h0;
            m_evals = 0;
            m_taken = 0;
        end else begin
            bit looked, equal, taken;
            looked = !m_pulse && branch_i && !stall_i;
            equal  = (rs_data_i == rt_data_i);
            taken  = looked && (bne_i ? !equal : equal);
            if (looked) m_evals++;
            if (taken) begin
                m_taken++;
                m_addr = pc_plus4_i + imm_i * 32'd4;
            end
            m_pulse = taken;
        end
    end

    // One compare process, every falling edge, away from the active edge.
    always @(negedge clk_i) begin
        check("model_taken", {31'b0, branchTaken_o}, {31'b0, m_pulse});
        check("model_flush", {31'b0, flush_o}, {31'b0, m_pulse});
        check("model_addr", addrTaken_o, m_addr);
`ifdef BRANCH_STATS_EN
        check("model_brcount", brCount_o, m_evals);
        check("model_takencount", takenCount_o, m_taken);
`endif
    end

    // ------------------------------------------------------------- stimulus
    // Inputs change 1 time unit after a rising edge and are held until the
    // next call's edge; after return the outputs of that edge are stable.
    task automatic apply(input logic br, input logic bne, input logic stall,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] pc, input logic [31:0] imm);
        branch_i   = br;
        bne_i      = bne;
        stall_i    = stall;
        rs_data_i  = rs;
        rt_data_i  = rt;
        pc_plus4_i = pc;
        imm_i      = imm;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic expect_out(input string name, input logic taken, input logic [31:0] addr);
        check({name, "_taken"}, {31'b0, branchTaken_o}, {31'b0, taken});
        check({name, "_flush"}, {31'b0, flush_o}, {31'b0, taken});
        check({name, "_addr"}, addrTaken_o, addr);
    endtask

    initial begin
        rst_i      = 1'b1;
        stall_i    = 1'b0;
        branch_i   = 1'b0;
        bne_i      = 1'b0;
        rs_data_i  = '0;
        rt_data_i  = '0;
        pc_plus4_i = '0;
        imm_i      = '0;
        #12;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        expect_out("reset", 1'b0, 32'h0);

        // beq taken: 0x100 + 3*4 = 0x10C, pulse for one cycle only.
        apply(1'b1, 1'b0, 1'b0, 32'd5, 32'd5, 32'h100, 32'd3);
        expect_out("beq_taken", 1'b1, 32'h10C);
        idle();
        expect_out("beq_after", 1'b0, 32'h10C);

        // bne with equal operands: never taken, target holds.
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b1, 1'b0, 32'd7, 32'd7, 32'h200, 32'd1);
            expect_out("bne_not_taken", 1'b0, 32'h10C);
        end

        // Stalled branch: no evaluation for two cycles, then exactly one pulse.
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b0, 1'b1, 32'd1, 32'd1, 32'h300, 32'd4);
            expect_out("stall_hold", 1'b0, 32'h10C);
        end
        apply(1'b1, 1'b0, 1'b0, 32'd1, 32'd1, 32'h300, 32'd4);
        expect_out("stall_release", 1'b1, 32'h310);
        idle();
        expect_out("stall_after", 1'b0, 32'h310);

        // Wrong path: the taken-looking beq during the redirect is ignored,
        // the next branch after it is correct-path and redirects again.
        apply(1'b1, 1'b0, 1'b0, 32'd9, 32'd9, 32'h400, 32'd0);
        expect_out("wp_first", 1'b1, 32'h400);
        apply(1'b1, 1'b0, 1'b0, 32'd3, 32'd3, 32'h500, 32'd0);
        expect_out("wp_ignored", 1'b0, 32'h400);
        apply(1'b1, 1'b0, 1'b0, 32'd2, 32'd2, 32'h600, 32'd1);
        expect_out("wp_next_branch", 1'b1, 32'h604);
        idle();
        expect_out("wp_after", 1'b0, 32'h604);

        // Address wrap and negative offset (bne with unequal operands).
        apply(1'b1, 1'b0, 1'b0, 32'hDEAD, 32'hDEAD, 32'hFFFF_FFFC, 32'd2);
        expect_out("wrap", 1'b1, 32'h4);
        idle();
        apply(1'b1, 1'b1, 1'b0, 32'd1, 32'd2, 32'h100, 32'hFFFF_FFFF);
        expect_out("neg_offset", 1'b1, 32'hFC);
        idle();

        // Reset mid-redirect: outputs drop immediately, without a clock edge.
        apply(1'b1, 1'b0, 1'b0, 32'd4, 32'd4, 32'h800, 32'd0);
        expect_out("pre_reset", 1'b1, 32'h800);
        branch_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        expect_out("async_reset", 1'b0, 32'h0);
        #2;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        expect_out("post_reset", 1'b0, 32'h0);

        // Three evaluations, two taken (the redirect-cycle branch is skipped).
        apply(1'b1, 1'b0, 1'b0, 32'd1, 32'd1, 32'h40, 32'd1);
        apply(1'b1, 1'b0, 1'b0, 32'd1, 32'd1, 32'h80, 32'd1);
        apply(1'b1, 1'b1, 1'b0, 32'd6, 32'd6, 32'h90, 32'd1);
        apply(1'b1, 1'b1, 1'b0, 32'd6, 32'd8, 32'hA0, 32'd2);
        expect_out("stats_last", 1'b1, 32'hA8);
        idle();
`ifdef BRANCH_STATS_EN
        check("stats_brcount", brCount_o, 32'd3);
        check("stats_takencount", takenCount_o, 32'd2);
`endif
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
